// File: rtl/bist_signature_analyzer.sv
// MISR-based signature analyzer for the BIST LED pattern generator: compresses
// NUM_PATTERNS strobed samples, then checks the result against a per-mode golden value.
module bist_signature_analyzer #(
   parameter int               WIDTH          = 16,
   parameter int               NUM_PATTERNS   = 64,
   parameter logic [WIDTH-1:0] POLY           = 16'h1021,
   parameter logic [WIDTH-1:0] SEED           = 16'h0000,
   parameter logic [WIDTH-1:0] GOLDEN_RING    = 16'h0000,
   parameter logic [WIDTH-1:0] GOLDEN_JOHNSON = 16'h0000,
   parameter logic [WIDTH-1:0] GOLDEN_LFSR    = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] led_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             aborted,
   output logic [WIDTH-1:0] signature
);

   localparam int              CW   = $clog2(NUM_PATTERNS + 1);
   localparam logic [CW-1:0]   LAST = CW'(NUM_PATTERNS - 1);
   localparam logic [1:0]      MODE_NONE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPRESS,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_sig, w_sig_next, w_misr, w_golden;
   logic [CW-1:0]    r_count, w_count_next;
   logic [1:0]       r_run_mode, w_run_mode_next;
   logic             r_pass, w_pass_next;
   logic             r_aborted, w_aborted_next;
   logic             w_start_ok, w_mode_changed;

   assign w_misr = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ led_in;
   assign w_start_ok     = start && (mode != MODE_NONE);
   assign w_mode_changed = (mode != r_run_mode);

   always_comb begin
      case (r_run_mode)
         2'b00:   w_golden = GOLDEN_RING;
         2'b01:   w_golden = GOLDEN_JOHNSON;
         2'b10:   w_golden = GOLDEN_LFSR;
         default: w_golden = '0;
      endcase
   end

   // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_next    = r_state;
      w_sig_next      = r_sig;
      w_count_next    = r_count;
      w_run_mode_next = r_run_mode;
      w_pass_next     = r_pass;
      w_aborted_next  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_ok) begin
               w_state_next    = S_COMPRESS;
               w_sig_next      = SEED;
               w_count_next    = '0;
               w_run_mode_next = mode;
               w_pass_next     = 1'b0;
            end
         end
         S_COMPRESS: begin
            // A mode change cancels the run; the sample in that cycle is dropped.
            if (w_mode_changed) begin
               w_state_next   = S_IDLE;
               w_aborted_next = 1'b1;
               w_pass_next    = 1'b0;
            end else if (sample_en) begin
               w_sig_next   = w_misr;
               w_count_next = r_count + 1'b1;
               if (r_count == LAST) w_state_next = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (w_mode_changed) begin
               w_state_next   = S_IDLE;
               w_aborted_next = 1'b1;
               w_pass_next    = 1'b0;
            end else begin
               w_state_next = S_DONE;
               w_pass_next  = (r_sig == w_golden);
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sig      <= SEED;
         r_count    <= '0;
         r_run_mode <= 2'b00;
         r_pass     <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_sig      <= w_sig_next;
         r_count    <= w_count_next;
         r_run_mode <= w_run_mode_next;
         r_pass     <= w_pass_next;
         r_aborted  <= w_aborted_next;
      end
   end

   assign busy      = (r_state == S_COMPRESS) || (r_state == S_COMPARE);
   assign done      = (r_state == S_DONE);
   assign pass      = r_pass;
   assign aborted   = r_aborted;
   assign signature = r_sig;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer: three instances with different run
// lengths and goldens share one stimulus stream; each step checks one instance.
module tb_bist_signature_analyzer;

   function automatic logic [15:0] pat_init(input logic [1:0] m);
      case (m)
         2'b00:   return 16'h0001;
         2'b01:   return 16'h0000;
         default: return 16'hACE1;
      endcase
   endfunction

   function automatic logic [15:0] pat_next(input logic [1:0] m, input logic [15:0] p);
      case (m)
         2'b00:   return {p[14:0], p[15]};
         2'b01:   return {p[14:0], ~p[15]};
         default: return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
      endcase
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
   endfunction

   function automatic logic [15:0] model_golden(input logic [1:0] m);
      logic [15:0] s;
      logic [15:0] p;
      s = 16'h0000;
      p = pat_init(m);
      for (int i = 0; i < 64; i++) begin
         s = misr_step(s, p);
         p = pat_next(m, p);
      end
      return s;
   endfunction

   localparam logic [15:0] G_RING    = model_golden(2'b00);
   localparam logic [15:0] G_JOHNSON = model_golden(2'b01);
   localparam logic [15:0] G_LFSR    = model_golden(2'b10);

   logic        clk, rst, start, sample_en;
   logic [1:0]  mode;
   logic [15:0] led_in;

   logic        w_busy4, w_done4, w_pass4, w_abort4;
   logic        w_busy2, w_done2, w_pass2, w_abort2;
   logic        w_busy64, w_done64, w_pass64, w_abort64;
   logic [15:0] w_sig4, w_sig2, w_sig64;

   int n_checks = 0;
   int n_errors = 0;

   bist_signature_analyzer #(.NUM_PATTERNS(4), .GOLDEN_RING(16'h000F)) u_p4 (
      .clk(clk), .rst(rst), .mode(mode), .start(start), .sample_en(sample_en),
      .led_in(led_in), .busy(w_busy4), .done(w_done4), .pass(w_pass4),
      .aborted(w_abort4), .signature(w_sig4));

   bist_signature_analyzer #(.NUM_PATTERNS(2), .GOLDEN_LFSR(16'h0000)) u_p2 (
      .clk(clk), .rst(rst), .mode(mode), .start(start), .sample_en(sample_en),
      .led_in(led_in), .busy(w_busy2), .done(w_done2), .pass(w_pass2),
      .aborted(w_abort2), .signature(w_sig2));

   bist_signature_analyzer #(.NUM_PATTERNS(64), .GOLDEN_RING(G_RING),
                             .GOLDEN_JOHNSON(G_JOHNSON), .GOLDEN_LFSR(G_LFSR)) u_p64 (
      .clk(clk), .rst(rst), .mode(mode), .start(start), .sample_en(sample_en),
      .led_in(led_in), .busy(w_busy64), .done(w_done64), .pass(w_pass64),
      .aborted(w_abort64), .signature(w_sig64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_step(input logic [15:0] d);
      sample_en = 1'b1;
      led_in    = d;
      tick();
      sample_en = 1'b0;
      led_in    = 16'h0000;
   endtask

   task automatic pulse_start(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [15:0] exp_sig, pat;

   initial begin
      rst = 1'b1; start = 1'b0; sample_en = 1'b0; mode = 2'b00; led_in = 16'h0000;
      tick(); tick();
      rst = 1'b0;
      check("reset_busy", 32'(w_busy64), 32'd0);
      check("reset_done", 32'(w_done64), 32'd0);
      check("reset_sig",  32'(w_sig64),  32'h0000);

      // T1: asynchronous reset in the middle of a run
      pulse_start(2'b01);
      repeat (3) sample_step(16'h0001);
      check("t1_busy_before", 32'(w_busy64), 32'd1);
      check("t1_sig_before",  32'(w_sig64),  32'h0007);
      rst = 1'b1;
      #1;
      check("t1_busy",    32'(w_busy64),  32'd0);
      check("t1_done",    32'(w_done64),  32'd0);
      check("t1_pass",    32'(w_pass64),  32'd0);
      check("t1_aborted", 32'(w_abort64), 32'd0);
      check("t1_sig",     32'(w_sig64),   32'h0000);
      tick();
      rst = 1'b0;

      // T2: four samples of 0001 on the 4-pattern instance, ring golden 000F
      pulse_start(2'b00);
      check("t2_busy", 32'(w_busy4), 32'd1);
      sample_step(16'h0001); check("t2_sig1", 32'(w_sig4), 32'h0001);
      sample_step(16'h0001); check("t2_sig2", 32'(w_sig4), 32'h0003);
      sample_step(16'h0001); check("t2_sig3", 32'(w_sig4), 32'h0007);
      sample_step(16'h0001); check("t2_sig4", 32'(w_sig4), 32'h000F);
      check("t2_compare_busy", 32'(w_busy4), 32'd1);
      check("t2_compare_done", 32'(w_done4), 32'd0);
      tick();
      check("t2_done", 32'(w_done4), 32'd1);
      check("t2_pass", 32'(w_pass4), 32'd1);
      check("t2_idle_busy", 32'(w_busy4), 32'd0);
      sample_step(16'hFFFF);
      check("t2_frozen_sig", 32'(w_sig4), 32'h000F);
      check("t2_done_held",  32'(w_done4), 32'd1);
      do_reset();

      // T3: feedback path on the 2-pattern instance, lfsr golden 0000 so pass=0
      pulse_start(2'b10);
      sample_step(16'h8000); check("t3_sig1", 32'(w_sig2), 32'h8000);
      sample_step(16'h8000); check("t3_sig2", 32'(w_sig2), 32'h9021);
      tick();
      check("t3_done", 32'(w_done2), 32'd1);
      check("t3_pass", 32'(w_pass2), 32'd0);
      do_reset();

      // T5: ignored start, start during compress, start with simultaneous sample
      pulse_start(2'b11);
      check("t5_nomode_busy", 32'(w_busy4), 32'd0);
      mode = 2'b00; start = 1'b1; sample_en = 1'b1; led_in = 16'h0001;
      tick();
      start = 1'b0; sample_en = 1'b0; led_in = 16'h0000;
      check("t5_start_busy", 32'(w_busy4), 32'd1);
      check("t5_start_sig",  32'(w_sig4),  32'h0000);
      repeat (3) sample_step(16'h0001);
      pulse_start(2'b00);
      check("t5_restart_busy", 32'(w_busy4), 32'd1);
      check("t5_restart_sig",  32'(w_sig4),  32'h0007);
      sample_step(16'h0001);
      check("t5_last_sig", 32'(w_sig4), 32'h000F);
      check("t5_not_done", 32'(w_done4), 32'd0);
      tick();
      check("t5_done", 32'(w_done4), 32'd1);
      check("t5_pass", 32'(w_pass4), 32'd1);
      do_reset();

      // T4: mode change after 3 of 64 samples aborts the run
      pulse_start(2'b01);
      repeat (3) sample_step(16'h0001);
      mode = 2'b00;
      tick();
      check("t4_aborted",  32'(w_abort64), 32'd1);
      check("t4_busy",     32'(w_busy64),  32'd0);
      check("t4_done",     32'(w_done64),  32'd0);
      check("t4_sig_held", 32'(w_sig64),   32'h0007);
      tick();
      check("t4_abort_pulse", 32'(w_abort64), 32'd0);

      // T6: full 64-sample runs in each mode against the bench MISR model
      for (int m = 0; m < 3; m++) begin
         mode = 2'(m);
         tick();
         pulse_start(2'(m));
         check("t6_seed", 32'(w_sig64), 32'h0000);
         exp_sig = 16'h0000;
         pat     = pat_init(2'(m));
         for (int i = 0; i < 64; i++) begin
            sample_step(pat);
            exp_sig = misr_step(exp_sig, pat);
            pat     = pat_next(2'(m), pat);
         end
         check("t6_sig",  32'(w_sig64),  32'(exp_sig));
         check("t6_busy", 32'(w_busy64), 32'd1);
         tick();
         check("t6_done", 32'(w_done64), 32'd1);
         check("t6_pass", 32'(w_pass64), 32'd1);
      end
      mode = 2'b00;
      tick();
      check("t6_mode_in_done_done", 32'(w_done64), 32'd1);
      check("t6_mode_in_done_pass", 32'(w_pass64), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
